// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode constants and fetch-stage enums.
// Imported by the fetch stage and its next-PC mux.
package cpu_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned CNT_W    = 16;

    localparam logic [OPCODE_W-1:0] HALT_OP  = 5'b11111;
    localparam logic [ADDR_W-1:0]   RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_TARGET
    } pc_sel_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC mux: hold, increment (wrapping) or load the branch target.
module fetch_next_pc
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [1:0]        sel,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        case (sel)
            PC_INC:    next_pc = pc + ADDR_W'(1);
            PC_TARGET: next_pc = branch_target;
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, fetch FSM, instruction-in-flight tracking across the
// memory's registered read, plus a saturating fetch counter.
module fetch_pc_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   address,
    output logic                instRead,
    output logic                inst_valid,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_count
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              inst_valid_q;
    logic              halted_q;
    logic [CNT_W-1:0]  count_q;
    logic [1:0]        pc_sel;
    logic              fetching;
    logic              halt_seen;

    assign fetching  = (state_q == FETCH);
    assign halt_seen = inst_valid_q && (opcode == HALT_OP);
    assign instRead  = fetching && !stall && !halt_seen && !branch_taken && !reset;

    // Branch outranks halt and stall; outside FETCH the PC never moves.
    always_comb begin
        pc_sel = PC_HOLD;
        if (fetching) begin
            if (branch_taken) begin
                pc_sel = PC_TARGET;
            end else if (!halt_seen && !stall) begin
                pc_sel = PC_INC;
            end
        end
    end

    fetch_next_pc u_next_pc (
        .pc            (pc_q),
        .branch_target (branch_target),
        .sel           (pc_sel),
        .next_pc       (pc_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            pc_q <= pc_d;
            if (instRead && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    inst_valid_q <= 1'b0;
                    if (run) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (branch_taken) begin
                        inst_valid_q <= 1'b0;
                    end else if (halt_seen) begin
                        state_q      <= HALTED;
                        halted_q     <= 1'b1;
                        inst_valid_q <= 1'b0;
                    end else if (!stall) begin
                        inst_valid_q <= 1'b1;
                        inst_pc_q    <= pc_q;
                    end
                end
                HALTED: begin
                    inst_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign address     = pc_q;
    assign inst_valid  = inst_valid_q;
    assign inst_pc     = inst_pc_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed stimulus with a scoreboard of expected inst_pc values
// and a behavioural instruction memory with a one-cycle registered read.
module tb_fetch_pc_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [4:0]  opcode = 5'b00000;
    logic [7:0]  address;
    logic        instRead;
    logic        inst_valid;
    logic [7:0]  inst_pc;
    logic        halted;
    logic [15:0] fetch_count;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_pc;
    logic       rd_q = 1'b0;
    logic [4:0] mem [256];

    fetch_pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .opcode        (opcode),
        .address       (address),
        .instRead      (instRead),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: registered read, output held while instRead is low.
    always @(posedge clk) begin
        if (instRead) opcode <= mem[address];
    end

    always @(posedge clk) rd_q <= instRead;

    // Monitor: a freshly presented instruction is one fetched on the previous edge.
    always @(negedge clk) begin
        if (inst_valid && rd_q) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_extra: got inst_pc=%h, required no instruction", inst_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (inst_pc !== exp_pc) begin
                    bad++;
                    $display("FAIL scoreboard_inst_pc: got %h, required %h", inst_pc, exp_pc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic drain(input string name);
        #3;
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        run = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        tick();
        check({name, "_rst_addr"}, address, 0);
        check({name, "_rst_valid"}, inst_valid, 0);
        check({name, "_rst_pc"}, inst_pc, 0);
        check({name, "_rst_halted"}, halted, 0);
        check({name, "_rst_count"}, fetch_count, 0);
        check({name, "_rst_rd"}, instRead, 0);
        reset = 1'b0;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 5'b00000;

        // 1: free-running fetch from reset
        do_reset("t1");
        run = 1'b1;
        push(8'h00); push(8'h01); push(8'h02);
        tick(); check("t1_addr0", address, 8'h00); check("t1_rd", instRead, 1);
        check("t1_first_bubble", inst_valid, 0);
        tick(); check("t1_addr1", address, 8'h01);
        tick(); check("t1_addr2", address, 8'h02);
        tick(); check("t1_addr3", address, 8'h03); check("t1_count", fetch_count, 3);
        check("t1_valid", inst_valid, 1); check("t1_inst_pc", inst_pc, 8'h02);
        drain("t1_drain");

        // 2: stall at pc=2
        do_reset("t2");
        run = 1'b1;
        push(8'h00); push(8'h01); push(8'h02); push(8'h03);
        tick(); tick(); tick();
        check("t2_addr_pre", address, 8'h02); check("t2_pc_pre", inst_pc, 8'h01);
        stall = 1'b1; #1;
        check("t2_rd_stall", instRead, 0);
        repeat (3) begin
            tick();
            check("t2_addr_hold", address, 8'h02);
            check("t2_valid_hold", inst_valid, 1);
            check("t2_pc_hold", inst_pc, 8'h01);
            check("t2_rd_hold", instRead, 0);
        end
        stall = 1'b0; #1;
        check("t2_rd_resume", instRead, 1);
        tick(); check("t2_addr3", address, 8'h03);
        tick(); check("t2_addr4", address, 8'h04); check("t2_count", fetch_count, 4);

        // 3: branch with simultaneous stall at pc=5
        push(8'h04); push(8'h40); push(8'h41);
        tick(); check("t3_addr5", address, 8'h05);
        branch_taken = 1'b1; branch_target = 8'h40; stall = 1'b1; #1;
        check("t3_rd_branch", instRead, 0);
        tick(); check("t3_addr_tgt", address, 8'h40); check("t3_bubble", inst_valid, 0);
        branch_taken = 1'b0; stall = 1'b0; #1;
        check("t3_rd_after", instRead, 1);
        tick(); check("t3_valid_tgt", inst_valid, 1); check("t3_pc_tgt", inst_pc, 8'h40);
        tick(); check("t3_addr42", address, 8'h42); check("t3_count", fetch_count, 7);
        drain("t3_drain");

        // 4: HALT at address 3
        do_reset("t4");
        mem[3] = HALT_OP;
        run = 1'b1;
        push(8'h00); push(8'h01); push(8'h02); push(8'h03);
        repeat (5) tick();
        check("t4_halt_presented", inst_pc, 8'h03); check("t4_halt_valid", inst_valid, 1);
        check("t4_not_yet_halted", halted, 0); check("t4_rd_halt_seen", instRead, 0);
        tick();
        check("t4_halted", halted, 1); check("t4_addr_frozen", address, 8'h04);
        check("t4_valid_off", inst_valid, 0); check("t4_rd_off", instRead, 0);
        branch_taken = 1'b1; branch_target = 8'h80;
        repeat (3) begin
            tick();
            check("t4_addr_ignore_br", address, 8'h04);
            check("t4_halted_stays", halted, 1);
            check("t4_rd_stays", instRead, 0);
        end
        check("t4_count", fetch_count, 4);
        branch_taken = 1'b0;
        drain("t4_drain");
        mem[3] = 5'b00000;
        do_reset("t4b");
        tick(); tick();
        check("t4_idle_rd", instRead, 0); check("t4_idle_addr", address, 8'h00);
        check("t4_idle_valid", inst_valid, 0);

        // 5: wrap past 8'hFF
        run = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 8'hFE; #1;
        check("t5_rd_branch", instRead, 0);
        tick(); check("t5_addr_fe", address, 8'hFE); check("t5_bubble", inst_valid, 0);
        branch_taken = 1'b0;
        push(8'hFE); push(8'hFF); push(8'h00); push(8'h01);
        tick(); check("t5_addr_ff", address, 8'hFF); check("t5_pc_fe", inst_pc, 8'hFE);
        tick(); check("t5_addr_00", address, 8'h00); check("t5_pc_ff", inst_pc, 8'hFF);
        tick(); check("t5_addr_01", address, 8'h01); check("t5_pc_00", inst_pc, 8'h00);
        tick(); check("t5_pc_01", inst_pc, 8'h01); check("t5_count", fetch_count, 4);
        drain("t5_drain");

        // 6: reset mid-stream at pc=7 with run held high
        push(8'h02); push(8'h03); push(8'h04); push(8'h05); push(8'h06);
        repeat (5) tick();
        check("t6_addr7", address, 8'h07); check("t6_valid", inst_valid, 1);
        reset = 1'b1; #1;
        check("t6_rd_in_reset", instRead, 0);
        drain("t6_drain_pre");
        tick();
        check("t6_rst_addr", address, 8'h00); check("t6_rst_valid", inst_valid, 0);
        check("t6_rst_pc", inst_pc, 8'h00); check("t6_rst_halted", halted, 0);
        check("t6_rst_count", fetch_count, 0);
        reset = 1'b0;
        push(8'h00); push(8'h01);
        tick(); check("t6_restart_addr", address, 8'h00); check("t6_restart_rd", instRead, 1);
        tick(); check("t6_addr1", address, 8'h01);
        tick(); check("t6_addr2", address, 8'h02); check("t6_pc1", inst_pc, 8'h01);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
